// File: rtl/led_pkg.sv
// led_pkg: shared types and defaults for the LED register bank.
//   led_mode_e        - register write mode (LOAD / SHIFT / SET / CLR)
//   LED_DIV_W_DEFAULT - default blink prescaler width
package led_pkg;

  typedef enum logic [1:0] {
    LED_LOAD  = 2'b00,
    LED_SHIFT = 2'b01,
    LED_SET   = 2'b10,
    LED_CLR   = 2'b11
  } led_mode_e;

  localparam int LED_DIV_W_DEFAULT = 16;

endpackage

// File: rtl/Led_Res_0603.sv
// Led_Res_0603: behavioural stand-in for one 0603 LED with series resistor.
//   drv_i - drive from the register bank
//   pad_o - level seen at the LED node (follows drv_i)
module Led_Res_0603 (
  input  logic drv_i,
  output logic pad_o
);

  assign pad_o = drv_i;

endmodule

// File: rtl/led_blink_prescaler.sv
// led_blink_prescaler: free-running blink phase generator.
//   clk_i   - clock
//   rst_ni  - async active-low reset (count=0, phase=1)
//   div_i   - half-period minus one, in clk_i cycles
//   phase_o - blink phase; 1 = blinking LEDs lit
module led_blink_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DIV_W-1:0] div_i,
  output logic             phase_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // >= rather than == so lowering div_i below the live count wraps on the
  // next edge instead of running the counter round the full range.
  always_comb begin
    cnt_d   = cnt_q + DIV_W'(1);
    phase_d = phase_q;
    if (cnt_q >= div_i) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/led_reg_bank.sv
// led_reg_bank: WIDTH-bit register bank with load/shift/set/clear writes,
// per-bit blink masking and one LED cell per bit.
//   clk_i, rst_ni - clock, async active-low reset
//   en_i          - write enable (0 = hold)
//   mode_i        - write mode (led_mode_e)
//   d_i           - load data or set/clear mask
//   ser_i         - serial input for SHIFT
//   blink_mask_i  - 1 = bit blinks when set
//   div_i         - blink half-period minus one
//   q_o           - register contents
//   ser_o         - q_o[WIDTH-1], for cascading
//   led_o         - LED drive value
module led_reg_bank
  import led_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DIV_W     = LED_DIV_W_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  led_mode_e        mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ser_i,
  input  logic [WIDTH-1:0] blink_mask_i,
  input  logic [DIV_W-1:0] div_i,
  output logic [WIDTH-1:0] q_o,
  output logic             ser_o,
  output logic [WIDTH-1:0] led_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shift_val;
  logic [WIDTH-1:0] led_drv;
  logic             phase;

  // A one-bit bank has nothing to shift along; the serial bit replaces it.
  if (WIDTH == 1) begin : g_shift1
    assign shift_val = ser_i;
  end else begin : g_shiftn
    assign shift_val = {q_q[WIDTH-2:0], ser_i};
  end

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      unique case (mode_i)
        LED_LOAD:  q_d = d_i;
        LED_SHIFT: q_d = shift_val;
        LED_SET:   q_d = q_q | d_i;
        LED_CLR:   q_d = q_q & ~d_i;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= RESET_VAL;
    else         q_q <= q_d;
  end

  led_blink_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .div_i   (div_i),
    .phase_o (phase)
  );

  // Mask is live (not registered) so a change shows up in the same cycle.
  assign led_drv = q_q & (~blink_mask_i | {WIDTH{phase}});

  for (genvar i = 0; i < WIDTH; i++) begin : g_led
    Led_Res_0603 u_led (
      .drv_i (led_drv[i]),
      .pad_o (led_o[i])
    );
  end

  assign q_o   = q_q;
  assign ser_o = q_q[WIDTH-1];

endmodule

// File: tb/tb_led_reg_bank.sv
module tb_led_reg_bank;
  import led_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        en;
  led_mode_e   mode;
  logic [7:0]  d, mask;
  logic        ser;
  logic [15:0] div;
  logic [7:0]  q, led;
  logic        ser_o;

  // cascade pair
  logic        en_c, sc, c0_so, c1_so;
  led_mode_e   mode_c;
  logic [3:0]  c0_q, c1_q, c0_led, c1_led;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_reg_bank #(.WIDTH(8), .DIV_W(16), .RESET_VAL(8'hA5)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .mode_i(mode), .d_i(d),
    .ser_i(ser), .blink_mask_i(mask), .div_i(div),
    .q_o(q), .ser_o(ser_o), .led_o(led)
  );

  led_reg_bank #(.WIDTH(4), .DIV_W(4), .RESET_VAL(4'h0)) u_c0 (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_c), .mode_i(mode_c), .d_i(4'h0),
    .ser_i(sc), .blink_mask_i(4'h0), .div_i(4'h0),
    .q_o(c0_q), .ser_o(c0_so), .led_o(c0_led)
  );

  led_reg_bank #(.WIDTH(4), .DIV_W(4), .RESET_VAL(4'h0)) u_c1 (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_c), .mode_i(mode_c), .d_i(4'h0),
    .ser_i(c0_so), .blink_mask_i(4'h0), .div_i(4'h0),
    .q_o(c1_q), .ser_o(c1_so), .led_o(c1_led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_led;
    logic       ph;
    rst_ni = 1'b0; en = 1'b0; mode = LED_LOAD; d = 8'h00; ser = 1'b0;
    mask = 8'h00; div = 16'd3; en_c = 1'b0; mode_c = LED_SHIFT; sc = 1'b0;

    // reset
    #12 rst_ni = 1'b1;
    #1;
    check("rst_q",    32'(q), 32'hA5);
    check("rst_led",  32'(led), 32'hA5);
    check("rst_ser",  32'(ser_o), 32'h1);
    check("rst_c0",   32'(c0_q), 32'h0);

    // write modes
    en = 1'b1;
    mode = LED_LOAD;  d = 8'h0F; tick(); check("load",  32'(q), 32'h0F);
    mode = LED_SET;   d = 8'hF0; tick(); check("set",   32'(q), 32'hFF);
    mode = LED_CLR;   d = 8'h3C; tick(); check("clr",   32'(q), 32'hC3);
    mode = LED_SHIFT; ser = 1'b1; tick(); check("shift", 32'(q), 32'h87);
    check("shift_ser", 32'(ser_o), 32'h1);
    check("led_nomask", 32'(led), 32'h87);

    // hold
    mode = LED_LOAD; d = 8'h55; tick(); check("load55", 32'(q), 32'h55);
    en = 1'b0; d = 8'hAA; ser = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); check("hold", 32'(q), 32'h55);
    end
    en = 1'b1; tick(); check("hold_rel", 32'(q), 32'hAA);

    // async reset between edges, then blink with div=3
    rst_ni = 1'b0; #1;
    check("async_q",   32'(q), 32'hA5);
    check("async_ser", 32'(ser_o), 32'h1);
    mode = LED_LOAD; d = 8'hFF; mask = 8'h0F; div = 16'd3;
    #1 rst_ni = 1'b1; #1;
    check("blink_pre", 32'(led), 32'hA5);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_led = (((k / 4) % 2) == 0) ? 8'hFF : 8'hF0;
      check("blink_div3", 32'(led), 32'(exp_led));
    end
    // after edge 12 the phase is 0; div=0 toggles every edge
    div = 16'd0; ph = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(); ph = ~ph;
      check("blink_div0", 32'(led), ph ? 32'hFF : 32'hF0);
    end
    // mask change acts in the same cycle
    mask = 8'h00; #1; check("mask_live", 32'(led), 32'hFF);

    // divider lowered below the live count
    mask = 8'hFF; div = 16'd100; d = 8'hFF;
    rst_ni = 1'b0; #1 rst_ni = 1'b1; #1;
    for (int k = 1; k <= 50; k++) tick();
    check("div100_50", 32'(led), 32'hFF);
    div = 16'd10;
    tick(); check("div_wrap", 32'(led), 32'h00);
    for (int k = 52; k <= 61; k++) tick();
    check("div10_61", 32'(led), 32'h00);
    tick(); check("div10_62", 32'(led), 32'hFF);
    for (int k = 63; k <= 72; k++) tick();
    check("div10_72", 32'(led), 32'hFF);
    tick(); check("div10_73", 32'(led), 32'h00);

    // cascade of two 4-bit banks
    en_c = 1'b1; sc = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("casc4_c0", 32'(c0_q), 32'hF);
    check("casc4_c1", 32'(c1_q), 32'h0);
    for (int k = 0; k < 4; k++) tick();
    check("casc8_c0", 32'(c0_q), 32'hF);
    check("casc8_c1", 32'(c1_q), 32'hF);
    check("casc_led", 32'(c1_led), 32'hF);
    check("casc_ser", 32'(c1_so), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_reg_bank.md
Name: led_reg_bank

Overview:
- Parametrised successor to the single-bit hold-enable DFF+LED merge cell.
- WIDTH-bit register bank with four write modes: load, shift, bit-set and bit-clear.
- Per-bit LED blink mask, driven by a shared programmable blink prescaler.
- Drives one Led_Res_0603 per bit for board-level status displays.
- Sits beside GPIO/debug logic; its outputs are also exported for readback and cascading.

Parameters:
- WIDTH, 8: number of register bits / LEDs; legal range 1..32.
- DIV_W, 16: width of the blink prescaler counter and of div_i.
- RESET_VAL, '0: WIDTH-bit value loaded into q_o on reset.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- en_i  input  1  write enable; 0 = hold (replaces the old dis semantics, inverted).
- mode_i  input  2  write mode, encoded as led_mode_e.
- d_i  input  WIDTH  load data, or set/clear mask.
- ser_i  input  1  serial input for shift mode.
- blink_mask_i  input  WIDTH  1 = bit blinks when set; 0 = steady.
- div_i  input  DIV_W  blink half-period minus one, in clk_i cycles.
- q_o  output  WIDTH  register contents.
- ser_o  output  1  q_o[WIDTH-1], for cascading banks.
- led_o  output  WIDTH  LED drive value; each bit also drives its Led_Res_0603 instance.

Behaviour:
- Reset (rst_ni=0, async assert, sync-free release):
  - q_o = RESET_VAL.
  - Prescaler count = 0, phase = 1.
  - led_o = RESET_VAL, since phase=1 means blinking bits are lit.
  - ser_o = RESET_VAL[WIDTH-1].
- Register update, one-cycle latency: on the rising edge with en_i=1, q_o becomes:
  - LOAD (2'b00): d_i.
  - SHIFT (2'b01): {q_o[WIDTH-2:0], ser_i}. For WIDTH=1: ser_i.
  - SET (2'b10): q_o | d_i.
  - CLR (2'b11): q_o & ~d_i.
- en_i=0: q_o holds; mode_i, d_i and ser_i are ignored.
- Prescaler:
  - Free-running and independent of en_i.
  - Each cycle: if cnt >= div_i, then cnt <= 0 and phase toggles; else cnt <= cnt+1.
  - Phase therefore toggles every div_i+1 cycles.
  - div_i=0: phase toggles every cycle.
  - div_i lowered below the current cnt: wraps on the next edge (the >= compare); no lock-up.
  - div_i=all-ones: full-range count, no overflow since the compare triggers first.
- LED output:
  - led_o = q_o & (~blink_mask_i | {WIDTH{phase}}).
  - Combinational from registered q_o and phase, and from the live blink_mask_i.
  - A mask change takes effect in the same cycle.
- Simultaneous events: a register write and a prescaler wrap in the same cycle are independent; both take effect.
- Reset mid-blink or mid-shift: all state returns to reset values immediately; there is no partial update.
- No X propagation: every flop is reset.

Decomposition:
- Package led_pkg:
  - typedef enum logic [1:0] led_mode_e {LED_LOAD, LED_SHIFT, LED_SET, LED_CLR}.
  - LED_DIV_W_DEFAULT = 16.
- Sub-module led_blink_prescaler:
  - Parameters: DIV_W.
  - Ports: clk_i, rst_ni, div_i, phase_o.
  - Contains the counter, compare and phase flop.
- Top level holds:
  - the register mux and flops (mux + DFF per bit, mapping to MUX/DFF cells);
  - the LED gating;
  - WIDTH Led_Res_0603 instances via a generate loop.

Test Plan:
- Reset value: RESET_VAL=8'hA5, rst_ni=0 then released, blink_mask_i=0 → q_o=8'hA5, led_o=8'hA5, ser_o=1; assert rst_ni=0 mid-cycle → q_o=8'hA5 without waiting for a clock edge.
- Modes: LOAD d_i=8'h0F → q_o=8'h0F; SET d_i=8'hF0 → 8'hFF; CLR d_i=8'h3C → 8'hC3; SHIFT ser_i=1 → 8'h87, ser_o=1; each with en_i=1, one cycle per step.
- Hold: q_o=8'h55, en_i=0, mode=LOAD, d_i=8'hAA for 10 cycles → q_o stays 8'h55; en_i=1 → 8'hAA the next cycle.
- Blink timing: q_o=8'hFF, blink_mask_i=8'h0F, div_i=3 → led_o alternates 8'hFF (4 cycles) / 8'hF0 (4 cycles); div_i=0 → alternates every cycle.
- Divider change: div_i=100, wait until cnt=50, then set div_i=10 → phase toggles on the next edge, then every 11 cycles.
- Cascade: two banks with ser_o→ser_i, WIDTH=4, SHIFT with ser_i=1 for 8 cycles from 0 → both q_o=4'hF; led_o equals q_o with mask=0.
